// File: rtl/ls_dma_engine_if.sv
// Bundle of command, local-store, external-bus and completion signals of the
// local-store quadword DMA engine; master = engine side, slave = surroundings.
interface ls_dma_engine_if #(
  parameter int LS_ADDR_W  = 15,
  parameter int DATA_W     = 128,
  parameter int EXT_ADDR_W = 32,
  parameter int LEN_W      = 8,
  parameter int TAG_W      = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [LS_ADDR_W-1:0]  cmd_ls_addr;
  logic [EXT_ADDR_W-1:0] cmd_ext_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic [TAG_W-1:0]      cmd_tag;

  logic                  ls_we;
  logic [LS_ADDR_W-1:0]  ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  ext_req_valid;
  logic                  ext_req_ready;
  logic                  ext_req_write;
  logic [EXT_ADDR_W-1:0] ext_req_addr;
  logic [DATA_W-1:0]     ext_req_wdata;
  logic                  ext_rdata_valid;
  logic [DATA_W-1:0]     ext_rdata;

  logic                  busy;
  logic                  done_valid;
  logic [TAG_W-1:0]      done_tag;
  logic                  done_err;

  modport master (
    input  cmd_valid, cmd_dir, cmd_ls_addr, cmd_ext_addr, cmd_len, cmd_tag,
    input  ls_rdata, ext_req_ready, ext_rdata_valid, ext_rdata,
    output cmd_ready, ls_we, ls_addr, ls_wdata,
    output ext_req_valid, ext_req_write, ext_req_addr, ext_req_wdata,
    output busy, done_valid, done_tag, done_err
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_ls_addr, cmd_ext_addr, cmd_len, cmd_tag,
    output ls_rdata, ext_req_ready, ext_rdata_valid, ext_rdata,
    input  cmd_ready, ls_we, ls_addr, ls_wdata,
    input  ext_req_valid, ext_req_write, ext_req_addr, ext_req_wdata,
    input  busy, done_valid, done_tag, done_err
  );
endinterface

// File: rtl/ls_dma_engine.sv
// Initiator-side quadword DMA between the 32 KB local store and external memory.
// One command at a time; GET fills the local store, PUT drains it.
module ls_dma_engine #(
  parameter int LS_ADDR_W  = 15,
  parameter int DATA_W     = 128,
  parameter int EXT_ADDR_W = 32,
  parameter int LEN_W      = 8,
  parameter int TAG_W      = 5
) (
  input logic             clk,
  input logic             rst,
  ls_dma_engine_if.master dma
);
  localparam int QW_SH = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {ST_IDLE, ST_GET, ST_PUT, ST_DONE} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued_q;
  logic [LEN_W-1:0]      rcvd_q;
  logic                  err_q;
  logic [LS_ADDR_W-1:0]  ls_base_q;
  logic [EXT_ADDR_W-1:0] ext_base_q;
  logic [TAG_W-1:0]      tag_q;

  logic cmd_fire;
  logic cmd_bad;
  logic req_fire;
  logic beat_ok;
  logic last_req;
  logic last_beat;

  function automatic logic [LS_ADDR_W-1:0] ls_qw(input logic [LS_ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]     idx);
    return base + (LS_ADDR_W'(idx) << QW_SH);
  endfunction

  function automatic logic [EXT_ADDR_W-1:0] ext_qw(input logic [EXT_ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]      idx);
    return base + (EXT_ADDR_W'(idx) << QW_SH);
  endfunction

  // Misaligned addresses or a zero length complete immediately with an error.
  assign cmd_fire  = rst && (state_q == ST_IDLE) && dma.cmd_valid;
  assign cmd_bad   = (dma.cmd_ls_addr[QW_SH-1:0] != '0) ||
                     (dma.cmd_ext_addr[QW_SH-1:0] != '0) ||
                     (dma.cmd_len == '0);
  assign req_fire  = dma.ext_req_ready &&
                     ((state_q == ST_PUT) || ((state_q == ST_GET) && (issued_q < len_q)));
  assign beat_ok   = (state_q == ST_GET) && dma.ext_rdata_valid && (rcvd_q < issued_q);
  assign last_req  = (issued_q == len_q - LEN_W'(1));
  assign last_beat = (rcvd_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_fire) state_d = cmd_bad ? ST_DONE : (dma.cmd_dir ? ST_PUT : ST_GET);
      ST_GET:  if (beat_ok && last_beat) state_d = ST_DONE;
      ST_PUT:  if (req_fire && last_req) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer progress; requests may run ahead of returned beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      issued_q <= '0;
      rcvd_q   <= '0;
      err_q    <= 1'b0;
    end else if (cmd_fire) begin
      len_q    <= dma.cmd_len;
      issued_q <= '0;
      rcvd_q   <= '0;
      err_q    <= cmd_bad;
    end else begin
      if (req_fire) issued_q <= issued_q + LEN_W'(1);
      if (beat_ok)  rcvd_q   <= rcvd_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      ls_base_q  <= dma.cmd_ls_addr;
      ext_base_q <= dma.cmd_ext_addr;
      tag_q      <= dma.cmd_tag;
    end
  end

  // Outputs are forced to zero for as long as reset is asserted.
  always_comb begin
    dma.cmd_ready     = 1'b0;
    dma.ls_we         = 1'b0;
    dma.ls_addr       = '0;
    dma.ls_wdata      = '0;
    dma.ext_req_valid = 1'b0;
    dma.ext_req_write = 1'b0;
    dma.ext_req_addr  = '0;
    dma.ext_req_wdata = '0;
    dma.busy          = 1'b0;
    dma.done_valid    = 1'b0;
    dma.done_tag      = '0;
    dma.done_err      = 1'b0;
    if (rst) begin
      unique case (state_q)
        ST_IDLE: dma.cmd_ready = 1'b1;
        ST_GET: begin
          dma.busy          = 1'b1;
          dma.ext_req_valid = (issued_q < len_q);
          dma.ext_req_addr  = ext_qw(ext_base_q, issued_q);
          dma.ls_addr       = ls_qw(ls_base_q, rcvd_q);
          if (beat_ok) begin
            dma.ls_we    = 1'b1;
            dma.ls_wdata = dma.ext_rdata;
          end
        end
        ST_PUT: begin
          dma.busy          = 1'b1;
          dma.ls_addr       = ls_qw(ls_base_q, issued_q);
          dma.ext_req_valid = 1'b1;
          dma.ext_req_write = 1'b1;
          dma.ext_req_addr  = ext_qw(ext_base_q, issued_q);
          dma.ext_req_wdata = dma.ls_rdata;
        end
        ST_DONE: begin
          dma.busy       = 1'b1;
          dma.done_valid = 1'b1;
          dma.done_tag   = tag_q;
          dma.done_err   = err_q;
        end
        default: ;
      endcase
    end
  end
endmodule
